// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD command sequencer.
//   - seq_state_e : sequencer FSM states
//   - cmd_t       : one queued command {rs, data}
//   - ADDR_*      : LCD slave register addresses (bit0 = RW, bit1 = RS)
//   - wr_addr()   : slave address for writing a command with a given RS
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    POLL_E   = 3'd1,
    POLL_GAP = 3'd2,
    WR_E     = 3'd3,
    WR_GAP   = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } cmd_t;

  localparam logic [1:0] ADDR_WR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_RD_STATUS = 2'd1;
  localparam logic [1:0] ADDR_WR_DATA   = 2'd2;

  // Character data goes to the data register, everything else is an instruction.
  function automatic logic [1:0] wr_addr(input logic rs);
    return rs ? ADDR_WR_DATA : ADDR_WR_CMD;
  endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// Host command channel plus LCD slave bus of the sequencer.
//   cmd_valid/cmd_ready/cmd_rs/cmd_data : host -> sequencer command handshake
//   lcd_address/lcd_read/lcd_write/lcd_begintransfer/lcd_writedata : sequencer -> LCD
//   lcd_readdata : LCD -> sequencer (bit7 = busy flag)
// Modport slave is the sequencer (it serves host commands); modport master is
// the surrounding system: the host and the LCD model.
interface lcd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic [1:0] lcd_address;
  logic       lcd_read;
  logic       lcd_write;
  logic       lcd_begintransfer;
  logic [7:0] lcd_writedata;
  logic [7:0] lcd_readdata;

  modport slave (
    input  cmd_valid, cmd_rs, cmd_data, lcd_readdata,
    output cmd_ready, lcd_address, lcd_read, lcd_write, lcd_begintransfer, lcd_writedata
  );

  modport master (
    output cmd_valid, cmd_rs, cmd_data, lcd_readdata,
    input  cmd_ready, lcd_address, lcd_read, lcd_write, lcd_begintransfer, lcd_writedata
  );
endinterface

// File: rtl/lcd_seq_fifo.sv
// Command FIFO for the LCD sequencer.
//   clk, reset_n : clock, async active-low reset (pointers and level cleared)
//   push_i       : push request (ignored while full)
//   pop_i        : pop request (ignored while empty)
//   wdata_i      : entry to push; rdata_o : head entry (valid while !empty_o)
//   full_o, empty_o : occupancy flags
module lcd_seq_fifo
  import lcd_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push_i,
  input  logic pop_i,
  input  cmd_t wdata_i,
  output cmd_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  cmd_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr_q];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage array: written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and level; simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/lcd_sequencer.sv
// LCD command sequencer: queues host commands, then for each one polls the
// LCD busy flag (read bursts at ADDR_RD_STATUS) until clear or until the poll
// limit, and finally writes the command byte. Each burst holds its strobe for
// E_PULSE_CYCLES and is followed by GAP_CYCLES with all strobes low.
//   clk, reset_n : clock, async active-low reset
//   bus          : host command handshake + LCD slave bus (slave modport)
//   seq_busy     : FIFO non-empty or a command in progress
//   timeout_err  : sticky, set when the poll limit is hit with busy still set
//   err_clear    : one-cycle clear of timeout_err (a same-cycle set wins)
module lcd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int E_PULSE_CYCLES = 25,
  parameter int GAP_CYCLES     = 50,
  parameter int POLL_LIMIT     = 4096,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  lcd_sequencer_if.slave  bus,
  output logic            seq_busy,
  output logic            timeout_err,
  input  logic            err_clear
);

  localparam int CNT_MAX = (E_PULSE_CYCLES > GAP_CYCLES) ? E_PULSE_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(POLL_LIMIT + 1);

  seq_state_e     state_q;
  cmd_t           cmd_q;
  logic [CW-1:0]  cyc_cnt_q;
  logic [PW-1:0]  poll_cnt_q;
  logic           busy_q;
  logic           timeout_q;
  logic           lcd_read_q;
  logic           lcd_write_q;
  logic           lcd_bt_q;
  logic [1:0]     lcd_addr_q;
  logic [7:0]     lcd_wdata_q;

  cmd_t           push_entry;
  cmd_t           fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic           e_last;
  logic           gap_last;

  assign push_entry = {bus.cmd_rs, bus.cmd_data};
  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
  assign e_last     = (cyc_cnt_q == CW'(E_PULSE_CYCLES - 1));
  assign gap_last   = (cyc_cnt_q == CW'(GAP_CYCLES - 1));

  lcd_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (bus.cmd_valid),
    .pop_i   (fifo_pop),
    .wdata_i (push_entry),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequencer FSM with registered LCD strobes. Strobes are set on the edge
  // that enters a burst state, so they line up exactly with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cyc_cnt_q   <= '0;
      poll_cnt_q  <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      lcd_read_q  <= 1'b0;
      lcd_write_q <= 1'b0;
      lcd_bt_q    <= 1'b0;
      lcd_addr_q  <= ADDR_WR_CMD;
      lcd_wdata_q <= 8'h00;
    end else begin
      // begintransfer is a one-cycle marker; only burst entry re-arms it.
      lcd_bt_q <= 1'b0;
      // The set inside POLL_E is assigned later and therefore overrides a clear.
      if (err_clear) timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cmd_q      <= fifo_head;
            state_q    <= POLL_E;
            cyc_cnt_q  <= '0;
            poll_cnt_q <= '0;
            lcd_read_q <= 1'b1;
            lcd_bt_q   <= 1'b1;
            lcd_addr_q <= ADDR_RD_STATUS;
          end
        end
        POLL_E: begin
          if (e_last) begin
            busy_q     <= bus.lcd_readdata[7];
            poll_cnt_q <= poll_cnt_q + PW'(1);
            if (bus.lcd_readdata[7] && (poll_cnt_q == PW'(POLL_LIMIT - 1))) begin
              timeout_q <= 1'b1;
            end
            lcd_read_q <= 1'b0;
            cyc_cnt_q  <= '0;
            state_q    <= POLL_GAP;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CW'(1);
          end
        end
        POLL_GAP: begin
          if (gap_last) begin
            cyc_cnt_q <= '0;
            lcd_bt_q  <= 1'b1;
            if (busy_q && (poll_cnt_q < PW'(POLL_LIMIT))) begin
              state_q    <= POLL_E;
              lcd_read_q <= 1'b1;
              lcd_addr_q <= ADDR_RD_STATUS;
            end else begin
              state_q     <= WR_E;
              lcd_write_q <= 1'b1;
              lcd_addr_q  <= wr_addr(cmd_q.rs);
              lcd_wdata_q <= cmd_q.data;
            end
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CW'(1);
          end
        end
        WR_E: begin
          if (e_last) begin
            lcd_write_q <= 1'b0;
            cyc_cnt_q   <= '0;
            state_q     <= WR_GAP;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CW'(1);
          end
        end
        WR_GAP: begin
          if (gap_last) begin
            cyc_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          cyc_cnt_q   <= '0;
          lcd_read_q  <= 1'b0;
          lcd_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready         = !fifo_full;
  assign bus.lcd_address       = lcd_addr_q;
  assign bus.lcd_read          = lcd_read_q;
  assign bus.lcd_write         = lcd_write_q;
  assign bus.lcd_begintransfer = lcd_bt_q;
  assign bus.lcd_writedata     = lcd_wdata_q;
  assign seq_busy              = !fifo_empty || (state_q != IDLE);
  assign timeout_err           = timeout_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
module tb_lcd_sequencer;
  localparam int E  = 3;
  localparam int G  = 2;
  localparam int PL = 4;
  localparam int FD = 4;

  logic clk;
  logic reset_n;
  logic seq_busy;
  logic timeout_err;
  logic err_clear;

  lcd_sequencer_if bus();

  lcd_sequencer #(.E_PULSE_CYCLES(E), .GAP_CYCLES(G), .POLL_LIMIT(PL), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .seq_busy    (seq_busy),
    .timeout_err (timeout_err),
    .err_clear   (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_wr;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy;
    int         exp_reads;
    logic [1:0] exp_addr;
    logic       exp_timeout;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  acc_t obs_q[$];
  acc_t exp_q[$];
  int   pend_busy[$];
  int   rd_cnt_cur = 0;
  int   proto_err = 0;
  int   n_begin = 0;
  bit   saw_not_ready = 0;
  bit   in_burst = 0;
  int   blen = 0;
  int   gap = 100;
  acc_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a command whose LCD reports busy for its first 'busy' polls is
  // polled min(busy+1, PL) times, then written at address {rs,0}.
  task automatic model_cmd(input logic rs, input logic [7:0] d, input int busy);
    acc_t a;
    int n;
    n = (busy + 1 < PL) ? busy + 1 : PL;
    for (int i = 0; i < n; i++) begin
      a.is_wr = 1'b0; a.addr = 2'd1; a.data = 8'h00;
      exp_q.push_back(a);
    end
    a.is_wr = 1'b1; a.addr = {rs, 1'b0}; a.data = d;
    exp_q.push_back(a);
  endtask

  // LCD model and bus monitor: answers polls and records every burst.
  always @(negedge clk) begin
    if (!reset_n) begin
      in_burst = 0;
      gap = 100;
      bus.lcd_readdata = 8'h00;
    end else begin
      if (bus.lcd_read && bus.lcd_write) proto_err++;
      if (bus.lcd_begintransfer) begin
        if (in_burst || !(bus.lcd_read || bus.lcd_write) || gap < G) proto_err++;
        in_burst = 1;
        blen = 1;
        n_begin++;
        cur.is_wr = bus.lcd_write;
        cur.addr  = bus.lcd_address;
        cur.data  = bus.lcd_writedata;
        if (bus.lcd_read) begin
          bus.lcd_readdata = {(pend_busy.size() > 0 && rd_cnt_cur < pend_busy[0]), 7'($urandom)};
          rd_cnt_cur++;
        end
      end else if (bus.lcd_read || bus.lcd_write) begin
        if (!in_burst || (bus.lcd_write != cur.is_wr) || (bus.lcd_address != cur.addr) ||
            (cur.is_wr && bus.lcd_writedata != cur.data)) proto_err++;
        blen++;
      end else begin
        if (in_burst) begin
          if (blen != E) proto_err++;
          obs_q.push_back(cur);
          if (cur.is_wr) begin
            if (pend_busy.size() > 0) void'(pend_busy.pop_front());
            rd_cnt_cur = 0;
          end
          gap = 0;
        end
        in_burst = 0;
        gap++;
      end
    end
  end

  task automatic push_cmd(input logic rs, input logic [7:0] d, input int busy);
    int w;
    w = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = rs;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && w < 200) begin
      saw_not_ready = 1;
      @(negedge clk);
      w++;
    end
    check("push_wait", w < 200, 1);
    pend_busy.push_back(busy);
    model_cmd(rs, d, busy);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!seq_busy && !in_burst) ok = 1;
    end
    check("idle_wait", ok, 1);
  endtask

  task automatic compare_accesses(input string name);
    int n;
    check({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_kind"}, obs_q[i].is_wr, exp_q[i].is_wr);
      check({name, "_addr"}, obs_q[i].addr, exp_q[i].addr);
      if (exp_q[i].is_wr) check({name, "_data"}, obs_q[i].data, exp_q[i].data);
    end
    check({name, "_protocol"}, proto_err, 0);
  endtask

  task automatic clear_all();
    obs_q.delete();
    exp_q.delete();
    pend_busy.delete();
    rd_cnt_cur = 0;
    proto_err  = 0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
    check("err_clear", timeout_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[5];
  bit   exp_to;
  int   nreads;
  int   nb;
  int   w;

  initial begin
    vecs[0] = '{rs: 1'b0, data: 8'h38, busy: 0,  exp_reads: 1, exp_addr: 2'd0, exp_timeout: 1'b0};
    vecs[1] = '{rs: 1'b1, data: 8'h41, busy: 2,  exp_reads: 3, exp_addr: 2'd2, exp_timeout: 1'b0};
    vecs[2] = '{rs: 1'b0, data: 8'h01, busy: 10, exp_reads: 4, exp_addr: 2'd0, exp_timeout: 1'b1};
    vecs[3] = '{rs: 1'b1, data: 8'h5A, busy: 3,  exp_reads: 4, exp_addr: 2'd2, exp_timeout: 1'b0};
    vecs[4] = '{rs: 1'b0, data: 8'h80, busy: 4,  exp_reads: 4, exp_addr: 2'd0, exp_timeout: 1'b1};

    reset_n = 1'b0;
    err_clear = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_rs = 1'b0;
    bus.cmd_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_read", bus.lcd_read, 0);
    check("rst_write", bus.lcd_write, 0);
    check("rst_bt", bus.lcd_begintransfer, 0);
    check("rst_addr", bus.lcd_address, 0);
    check("rst_wdata", bus.lcd_writedata, 0);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_busy", seq_busy, 0);
    check("rst_timeout", timeout_err, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: lcd_read rises in the second cycle after acceptance.
    clear_all();
    bus.cmd_valid = 1'b1; bus.cmd_rs = 1'b0; bus.cmd_data = 8'h38;
    pend_busy.push_back(0);
    model_cmd(1'b0, 8'h38, 0);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("lat_read_k1", bus.lcd_read, 0);
    check("lat_busy_k1", seq_busy, 1);
    @(negedge clk);
    check("lat_read_k2", bus.lcd_read, 1);
    check("lat_bt_k2", bus.lcd_begintransfer, 1);
    check("lat_addr_k2", bus.lcd_address, 1);
    wait_idle();
    compare_accesses("latency");

    // Table of single commands with controlled busy-flag behaviour.
    for (int v = 0; v < 5; v++) begin
      clear_all();
      pulse_clear();
      push_cmd(vecs[v].rs, vecs[v].data, vecs[v].busy);
      wait_idle();
      nreads = 0;
      foreach (obs_q[i]) if (!obs_q[i].is_wr) nreads++;
      check($sformatf("vec%0d_reads", v), nreads, vecs[v].exp_reads);
      check($sformatf("vec%0d_last_wr", v), obs_q.size() > 0 ? obs_q[obs_q.size()-1].is_wr : 0, 1);
      if (obs_q.size() > 0) begin
        check($sformatf("vec%0d_wr_addr", v), obs_q[obs_q.size()-1].addr, vecs[v].exp_addr);
        check($sformatf("vec%0d_wr_data", v), obs_q[obs_q.size()-1].data, vecs[v].data);
      end
      check($sformatf("vec%0d_timeout", v), timeout_err, vecs[v].exp_timeout);
      compare_accesses($sformatf("vec%0d", v));
    end
    pulse_clear();

    // Back-to-back commands with cmd_valid held high: FIFO fills, nothing lost.
    clear_all();
    saw_not_ready = 0;
    for (int i = 0; i < 6; i++) push_cmd(i[0], 8'h30 + 8'(i), 0);
    check("b2b_ready_dropped", saw_not_ready, 1);
    wait_idle();
    compare_accesses("b2b");

    // Randomized commands against the reference model.
    clear_all();
    exp_to = 0;
    for (int i = 0; i < 12; i++) begin
      int b;
      b = $urandom_range(0, 5);
      if (b >= PL) exp_to = 1;
      push_cmd(1'($urandom), 8'($urandom), b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    compare_accesses("rand");
    check("rand_timeout", timeout_err, exp_to);
    pulse_clear();

    // Reset in the second cycle of a write burst with more commands queued.
    clear_all();
    push_cmd(1'b1, 8'h55, 0);
    push_cmd(1'b0, 8'h66, 0);
    push_cmd(1'b1, 8'h77, 0);
    w = 0;
    while (!bus.lcd_write && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("rst_mid_wait", w < 500, 1);
    check("rst_mid_bt", bus.lcd_begintransfer, 1);
    @(posedge clk);
    #1;
    check("rst_mid_in_burst", bus.lcd_write, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_write_drop", bus.lcd_write, 0);
    check("rst_mid_read", bus.lcd_read, 0);
    check("rst_mid_ready", bus.cmd_ready, 1);
    check("rst_mid_busy", seq_busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_all();
    nb = n_begin;
    repeat (40) @(negedge clk);
    check("post_rst_no_access", n_begin - nb, 0);
    check("post_rst_busy", seq_busy, 0);
    check("post_rst_ready", bus.cmd_ready, 1);
    check("post_rst_timeout", timeout_err, 0);
    check("post_rst_protocol", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 SHALL have parameter E_PULSE_CYCLES, default 25, cycles read/write held asserted per LCD access (500 ns at 50 MHz); legal values >=1.
REQ-002 SHALL have parameter GAP_CYCLES, default 50, idle cycles after each access (strobe low); legal values >=1.
REQ-003 SHALL have parameter POLL_LIMIT, default 4096, maximum busy-flag reads per command before timeout.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, command FIFO entries (power of 2).
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port cmd_valid, input, 1: host presents a command.
REQ-008 Port cmd_ready, output, 1: FIFO not full; a command is accepted on a clk edge with cmd_valid and cmd_ready both high.
REQ-009 Port cmd_rs, input, 1: 0 = instruction, 1 = character data.
REQ-010 Port cmd_data, input, 8: instruction or character byte.
REQ-011 Port seq_busy, output, 1: FIFO non-empty or FSM not IDLE.
REQ-012 Port timeout_err, output, 1: sticky; cleared by err_clear.
REQ-013 Port err_clear, input, 1: single-cycle clear of timeout_err.
REQ-014 Port lcd_address, output, 2: to LCD slave; bit0 = RW, bit1 = RS.
REQ-015 Port lcd_read, lcd_write, lcd_begintransfer, outputs, 1 each: LCD slave strobes.
REQ-016 Port lcd_writedata, output, 8; port lcd_readdata, input, 8: LCD slave data paths.

Function
REQ-017 SHALL use FSM states IDLE, POLL_E, POLL_GAP, WR_E, WR_GAP.
REQ-018 IDLE -> POLL_E when FIFO non-empty; head entry latched into cmd register and popped on that transition.
REQ-019 POLL_E SHALL drive lcd_address=1 and lcd_read=1 for exactly E_PULSE_CYCLES cycles, sampling lcd_readdata[7] on the last cycle.
REQ-020 POLL_GAP SHALL hold all strobes low for GAP_CYCLES cycles; then -> POLL_E if the sampled busy bit=1 and the poll count is below POLL_LIMIT, else -> WR_E.
REQ-021 On the POLL_LIMIT-th busy poll, timeout_err SHALL set and the write SHALL proceed anyway.
REQ-022 WR_E SHALL drive lcd_address={cmd_rs,0}, lcd_writedata=cmd_data and lcd_write=1 for E_PULSE_CYCLES cycles.
REQ-023 WR_GAP SHALL hold all strobes low for GAP_CYCLES cycles, then -> IDLE.
REQ-024 lcd_begintransfer SHALL be high only in the first cycle of each POLL_E and WR_E burst.
REQ-025 lcd_read and lcd_write SHALL never both be high; lcd_address and lcd_writedata SHALL be stable throughout each burst.
REQ-026 Latency: for a command accepted into an empty FIFO with the FSM in IDLE, lcd_read SHALL rise in the second cycle after the acceptance cycle.
REQ-027 FIFO full: cmd_ready=0; a push attempted while full SHALL be ignored.
REQ-028 Simultaneous push and pop SHALL be allowed; the level is unchanged and the order is preserved.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; level counter SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-030 If err_clear and a timeout set occur in the same cycle, set SHALL win.

Reset
REQ-031 While reset_n=0: FSM=IDLE, FIFO empty, counters=0, timeout_err=0, lcd_read=lcd_write=lcd_begintransfer=0, lcd_address=0, lcd_writedata=0, cmd_ready=1, seq_busy=0.
REQ-032 Reset mid-access SHALL drop lcd_read/lcd_write immediately, without waiting for clk; the partly issued command is discarded.

Structure
REQ-033 Shared package lcd_seq_pkg SHALL hold the state enum and the address constants ADDR_WR_CMD=0, ADDR_RD_STATUS=1, ADDR_WR_DATA=2.
REQ-034 The command FIFO (9-bit entries {rs,data}) SHALL be the sub-module lcd_seq_fifo; the FSM and cycle counters stay in lcd_sequencer.

Verification (bench params: E_PULSE_CYCLES=3, GAP_CYCLES=2, POLL_LIMIT=4, FIFO_DEPTH=4)
REQ-035 Push {0,0x38} with lcd_readdata=0x00 -> read burst at addr 1 for 3 cycles, 2 gap cycles, write burst at addr 0 with data 0x38 for 3 cycles, then IDLE; one begintransfer per burst.
REQ-036 Push {1,0x41} with busy=1 for the first 2 polls -> 3 read bursts, then a write burst at addr 2 with data 0x41; timeout_err stays 0.
REQ-037 Busy held at 1 -> exactly 4 read bursts, timeout_err=1, write still issued; err_clear pulse -> timeout_err=0.
REQ-038 Push 6 commands back-to-back with cmd_valid held high -> cmd_ready drops when 4 are queued; all 6 are written to the LCD in order with no loss.
REQ-039 Assert reset_n=0 during the second cycle of a WR_E burst -> lcd_write=0 before the next clk edge; after release the FSM is in IDLE, FIFO empty, and no further LCD accesses occur.
